// File: rtl/sysu_74ip_pkg.sv
// Shared definitions for the sysu 74-series IP blocks: FSM state encodings
// and the constant-function log2 used to size counters.
package sysu_74ip_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Smallest r with 2**r >= n; returns 0 for n <= 1.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/sysu_mod_counter.sv
// Modulo-N up counter: enable, synchronous clear-to-zero, terminal count at N-1.
// Single-cycle update; the counter wraps to 0 when enabled at terminal count.
module sysu_mod_counter
    import sysu_74ip_pkg::*;
#(
    parameter int N  = 8,
    parameter int CW = (clog2(N) < 1) ? 1 : clog2(N)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          en_i,
    input  logic          clr_i,
    output logic [CW-1:0] cnt_o,
    output logic          tc_o
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tc_o  = (cnt_q == CW'(N - 1));
    assign cnt_o = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tc_o ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sysu_piso_tx.sv
// Parallel-in/serial-out transmitter, MSB first, with a valid/ready load port.
// First bit on Q one cycle after accept; HOLD freezes everything and drops READY.
module sysu_piso_tx
    import sysu_74ip_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int Delay = 0
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic [WIDTH-1:0] D,
    input  logic             VALID,
    output logic             READY,
    input  logic             HOLD,
    output logic             Q,
    output logic             FRAME,
    output logic             DONE
);

    localparam int CW = clog2(WIDTH);

    if (WIDTH < 2 || Delay < 0) begin : g_param_chk
        $error("sysu_piso_tx: WIDTH must be >= 2 and Delay >= 0");
    end

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic             q_q, q_d;
    logic             frame_q, frame_d;
    logic             done_q, done_d;
    logic [CW-1:0]    cnt;
    logic             last_bit;
    logic             cnt_en;
    logic             cnt_clr;
    logic             accept;

    sysu_mod_counter #(
        .N  (WIDTH),
        .CW (CW)
    ) u_cnt (
        .clk_i (CLK),
        .rst_i (CLR),
        .en_i  (cnt_en),
        .clr_i (cnt_clr),
        .cnt_o (cnt),
        .tc_o  (last_bit)
    );

    // A new word may load while idle or on the edge that retires the last bit.
    assign READY  = !HOLD && (state_q == ST_IDLE ||
                              (state_q == ST_SHIFT && cnt == CW'(WIDTH - 1)));
    assign accept = VALID && READY;

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        done_d  = 1'b0;
        cnt_en  = 1'b0;
        cnt_clr = 1'b0;
        if (state_q == ST_SHIFT && !HOLD && last_bit) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
            cnt_clr = 1'b1;
        end else if (state_q == ST_SHIFT && !HOLD) begin
            sr_d   = {sr_q[WIDTH-2:0], 1'b0};
            cnt_en = 1'b1;
        end
        if (accept) begin
            sr_d    = D;
            state_d = ST_SHIFT;
            cnt_clr = 1'b1;
            cnt_en  = 1'b0;
        end
        q_d     = (state_d == ST_SHIFT) ? sr_d[WIDTH-1] : 1'b0;
        frame_d = (state_d == ST_SHIFT);
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            q_q     <= 1'b0;
            frame_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            q_q     <= q_d;
            frame_q <= frame_d;
            done_q  <= done_d;
        end
    end

    assign Q     = q_q;
    assign FRAME = frame_q;
    assign DONE  = done_q;

endmodule

// File: tb/tb_sysu_piso_tx.sv
// Bench for sysu_piso_tx: constant vector table, directed multi-cycle sequences
// and a randomized run against a word/bit-index reference model.
module tb_sysu_piso_tx;

    logic       clk = 1'b0;
    logic       clr;
    logic [7:0] d;
    logic       valid, hold;
    logic       ready, q, frame, done;
    logic [1:0] d2;
    logic       valid2, hold2;
    logic       ready2, q2, frame2, done2;

    int checks   = 0;
    int failures = 0;

    // Reference model: the word being sent and the index of the bit now on Q.
    logic       m_busy;
    logic [7:0] m_word;
    int         m_pos;
    logic       m_done;

    logic last_r, last_q, last_f, last_dn;

    typedef struct {
        logic [7:0] d;
        logic       v;
        logic       h;
        logic       r;
        logic       q;
        logic       f;
        logic       dn;
    } vec_t;

    vec_t tbl[10];

    always #5 clk = ~clk;

    sysu_piso_tx #(.WIDTH(8), .Delay(0)) u_dut (
        .CLK(clk), .CLR(clr), .D(d), .VALID(valid), .READY(ready),
        .HOLD(hold), .Q(q), .FRAME(frame), .DONE(done)
    );

    sysu_piso_tx #(.WIDTH(2), .Delay(0)) u_dut2 (
        .CLK(clk), .CLR(clr), .D(d2), .VALID(valid2), .READY(ready2),
        .HOLD(hold2), .Q(q2), .FRAME(frame2), .DONE(done2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0;
        m_word = '0;
        m_pos  = 0;
        m_done = 1'b0;
    endtask

    // One clock: drive inputs, check READY before the edge, advance the model
    // at the edge, then check the registered outputs just after it.
    task automatic cyc(input logic [7:0] di, input logic vi, input logic hi);
        logic mr;
        d = di; valid = vi; hold = hi;
        #1;
        mr = !hi && (!m_busy || m_pos == 0);
        chk("ready", ready, mr);
        last_r = ready;
        @(posedge clk);
        m_done = m_busy && !hi && m_pos == 0;
        if (vi && mr) begin
            m_busy = 1'b1;
            m_word = di;
            m_pos  = 7;
        end else if (m_busy && !hi) begin
            if (m_pos == 0) m_busy = 1'b0;
            else m_pos--;
        end
        #1;
        chk("q", q, m_busy ? m_word[m_pos] : 1'b0);
        chk("frame", frame, m_busy);
        chk("done", done, m_done);
        last_q = q; last_f = frame; last_dn = done;
    endtask

    task automatic async_reset();
        #3;
        clr = 1'b1;
        #1;
        chk("rst_q", q, 1'b0);
        chk("rst_frame", frame, 1'b0);
        chk("rst_done", done, 1'b0);
        model_reset();
        @(negedge clk);
        clr = 1'b0;
        hold = 1'b0;
        #1;
        chk("rst_ready", ready, 1'b1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] bits16;
        logic [16:0] dmask;
        logic [7:0]  bits8;
        logic [3:0]  bits4;
        int nframe, ndone, nb;

        tbl[0] = '{8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[1] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[3] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[6] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[7] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[8] = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[9] = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

        clr = 1'b1; d = '0; valid = 1'b0; hold = 1'b0;
        d2 = '0; valid2 = 1'b0; hold2 = 1'b0;
        model_reset();
        #12;
        chk("init_q", q, 1'b0);
        chk("init_frame", frame, 1'b0);
        chk("init_done", done, 1'b0);
        clr = 1'b0;
        #1;
        chk("init_ready", ready, 1'b1);
        @(posedge clk);
        #1;

        // Single word A5 against the constant table.
        for (int i = 0; i < 10; i++) begin
            cyc(tbl[i].d, tbl[i].v, tbl[i].h);
            chk($sformatf("tbl%0d_ready", i), last_r, tbl[i].r);
            chk($sformatf("tbl%0d_q", i), last_q, tbl[i].q);
            chk($sformatf("tbl%0d_frame", i), last_f, tbl[i].f);
            chk($sformatf("tbl%0d_done", i), last_dn, tbl[i].dn);
        end

        // Back-to-back FF then 01 with VALID held high.
        nframe = 0; bits16 = '0; dmask = '0;
        for (int i = 0; i < 17; i++) begin
            cyc((i < 8) ? 8'hFF : 8'h01, (i <= 8), 1'b0);
            if (last_f) begin
                nframe++;
                bits16 = {bits16[14:0], last_q};
            end
            dmask[i] = last_dn;
        end
        chk("b2b_frame_cycles", nframe, 16);
        chk("b2b_bits", bits16, 16'hFF01);
        chk("b2b_done_pos", dmask, 17'h10100);

        // HOLD for three cycles after the third bit of C3.
        nframe = 0; bits8 = '0; nb = 0;
        for (int i = 0; i < 13; i++) begin
            cyc(8'hC3, (i == 0), (i >= 3 && i <= 5));
            if (i >= 3 && i <= 5) chk("hold_ready", last_r, 1'b0);
            if (last_f) nframe++;
            if (last_f && !(i >= 3 && i <= 5)) begin
                bits8 = {bits8[6:0], last_q};
                nb++;
            end
        end
        chk("hold_frame_cycles", nframe, 11);
        chk("hold_nbits", nb, 8);
        chk("hold_bits", bits8, 8'hC3);

        // Async reset mid-word A5, then abort of 5A followed by a clean 81.
        cyc(8'hA5, 1'b1, 1'b0);
        cyc(8'h00, 1'b0, 1'b0);
        cyc(8'h00, 1'b0, 1'b0);
        async_reset();

        cyc(8'h5A, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cyc(8'h00, 1'b0, 1'b0);
        async_reset();
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(8'h00, 1'b0, 1'b0);
            if (last_dn) ndone++;
        end
        chk("abort_no_done", ndone, 0);
        bits8 = '0; ndone = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(8'h81, (i == 0), 1'b0);
            if (last_f) bits8 = {bits8[6:0], last_q};
            if (last_dn) ndone++;
        end
        chk("after_abort_bits", bits8, 8'h81);
        chk("after_abort_done", ndone, 1);

        // WIDTH=2 instance: single word 10, then back-to-back 01,11.
        d2 = 2'b10; valid2 = 1'b1;
        #1 chk("w2_ready0", ready2, 1'b1);
        @(posedge clk); #1;
        chk("w2_q0", q2, 1'b1); chk("w2_f0", frame2, 1'b1); chk("w2_dn0", done2, 1'b0);
        valid2 = 1'b0;
        #1 chk("w2_ready1", ready2, 1'b0);
        @(posedge clk); #1;
        chk("w2_q1", q2, 1'b0); chk("w2_f1", frame2, 1'b1);
        #1 chk("w2_ready2", ready2, 1'b1);
        @(posedge clk); #1;
        chk("w2_dn2", done2, 1'b1); chk("w2_f2", frame2, 1'b0); chk("w2_q2", q2, 1'b0);
        bits4 = '0; ndone = 0; nframe = 0;
        for (int i = 0; i < 5; i++) begin
            d2 = (i < 2) ? 2'b01 : 2'b11;
            valid2 = (i <= 2);
            @(posedge clk); #1;
            if (frame2) begin
                nframe++;
                bits4 = {bits4[2:0], q2};
            end
            if (done2) ndone++;
        end
        valid2 = 1'b0;
        chk("w2_b2b_bits", bits4, 4'b0111);
        chk("w2_b2b_frame", nframe, 4);
        chk("w2_b2b_done", ndone, 2);

        // Randomized traffic with sporadic HOLD.
        for (int i = 0; i < 600; i++) begin
            cyc(8'($urandom), ($urandom_range(0, 2) != 0), ($urandom_range(0, 5) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
